// File: rtl/up_dn_counter_pkg.sv
// Shared mode encodings and direction constant for the limited up/down counter.
package up_dn_counter_pkg;

  localparam logic [1:0] MODE_SAT    = 2'd0;
  localparam logic [1:0] MODE_WRAP   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/up_dn_step_calc.sv
// Combinational next-value calculator: one step toward a limit, with snap-in,
// overshoot handling per limit mode and bounce direction flip.
module up_dn_step_calc
  import up_dn_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic             i_dir_up,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_evt,
  output logic             o_flip,
  output logic             o_snap
);

  logic [WIDTH:0]   w_up;
  logic [WIDTH:0]   w_dn;
  logic [WIDTH-1:0] w_lim;
  logic [WIDTH-1:0] w_opp;
  logic [WIDTH-1:0] w_stepped;
  logic             w_ovr;
  logic             w_land;

  // Extra MSB keeps the carry/borrow so a step never silently wraps modulo 2^WIDTH.
  assign w_up = {1'b0, i_cnt} + {1'b0, i_step};
  assign w_dn = {1'b0, i_cnt} - {1'b0, i_step};

  // Select the approached limit, the opposite limit and the raw stepped value.
  always_comb begin
    if (i_dir_up) begin
      w_lim     = i_hi;
      w_opp     = i_lo;
      w_stepped = w_up[WIDTH-1:0];
      w_ovr     = (w_up > {1'b0, i_hi});
      w_land    = (w_up == {1'b0, i_hi});
    end else begin
      w_lim     = i_lo;
      w_opp     = i_hi;
      w_stepped = w_dn[WIDTH-1:0];
      w_ovr     = w_dn[WIDTH] | (w_dn[WIDTH-1:0] < i_lo);
      w_land    = (w_dn == {1'b0, i_lo});
    end
  end

  // Resolve next value and event flags.
  always_comb begin
    o_nxt  = i_cnt;
    o_evt  = 1'b0;
    o_flip = 1'b0;
    o_snap = 1'b0;
    if (i_cnt < i_lo) begin
      o_snap = 1'b1;
      o_nxt  = i_lo;
    end else if (i_cnt > i_hi) begin
      o_snap = 1'b1;
      o_nxt  = i_hi;
    end else if (w_ovr || (w_land && (i_mode == MODE_BOUNCE))) begin
      case (i_mode)
        MODE_WRAP: begin
          o_nxt = w_opp;
          o_evt = 1'b1;
        end
        MODE_BOUNCE: begin
          o_nxt  = w_lim;
          o_evt  = 1'b1;
          o_flip = 1'b1;
        end
        MODE_SAT: o_nxt = w_lim;
        default:  o_nxt = w_lim;
      endcase
    end else begin
      o_nxt = w_stepped;
    end
  end

endmodule

// File: rtl/up_dn_counter_lim.sv
// Up/down counter with programmable limits, step and saturate/wrap/bounce modes.
// Holds Counter/DIR/TC registers and the reset > error > load > count priority.
module up_dn_counter_lim
  import up_dn_counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic             EN,
  input  logic [WIDTH-1:0] STEP,
  input  logic [WIDTH-1:0] LIM_LO,
  input  logic [WIDTH-1:0] LIM_HI,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             DIR,
  output logic             TC,
  output logic             ERR
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_nxt;
  logic             w_dir_up;
  logic             w_count;
  logic             w_evt;
  logic             w_flip;
  logic             w_snap;

  assign ERR     = (LIM_LO > LIM_HI);
  assign High    = (r_cnt == LIM_HI);
  assign Low     = (r_cnt == LIM_LO);
  assign Counter = r_cnt;
  assign DIR     = r_dir;
  assign TC      = r_tc;

  // In bounce mode the stored direction rules; otherwise Down wins over Up.
  assign w_dir_up = (MODE == MODE_BOUNCE) ? r_dir : ~Down;
  assign w_count  = EN & (STEP != {WIDTH{1'b0}}) & (Up | Down);

  // Clamp the load value into the configured window.
  always_comb begin
    if (IN < LIM_LO) begin
      w_load_val = LIM_LO;
    end else if (IN > LIM_HI) begin
      w_load_val = LIM_HI;
    end else begin
      w_load_val = IN;
    end
  end

  up_dn_step_calc #(
    .WIDTH (WIDTH)
  ) u_step_calc (
    .i_cnt    (r_cnt),
    .i_step   (STEP),
    .i_lo     (LIM_LO),
    .i_hi     (LIM_HI),
    .i_dir_up (w_dir_up),
    .i_mode   (MODE),
    .o_nxt    (w_nxt),
    .o_evt    (w_evt),
    .o_flip   (w_flip),
    .o_snap   (w_snap)
  );

  // Counter, direction and terminal-count registers with priority resolution.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= RST_VAL;
      r_dir <= DIR_UP;
      r_tc  <= 1'b0;
    end else if (ERR) begin
      r_tc <= 1'b0;
    end else if (Load) begin
      r_cnt <= w_load_val;
      r_tc  <= 1'b0;
    end else if (w_count) begin
      r_cnt <= w_nxt;
      r_dir <= (w_flip && !w_snap) ? ~r_dir : r_dir;
      r_tc  <= w_evt & ~w_snap;
    end else begin
      r_tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_dn_counter_lim.sv
// Directed self-checking bench for up_dn_counter_lim (WIDTH = 8, RST_VAL = 0).
module tb_up_dn_counter_lim;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN = 8'd0;
  logic       Load = 1'b0;
  logic       Up = 1'b0;
  logic       Down = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] STEP = 8'd0;
  logic [7:0] LIM_LO = 8'd0;
  logic [7:0] LIM_HI = 8'd0;
  logic [1:0] MODE = 2'd0;
  logic [7:0] Counter;
  logic       High, Low, DIR, TC, ERR;

  int n_tests = 0;
  int n_fail  = 0;

  up_dn_counter_lim #(.WIDTH(8), .RST_VAL(8'd0)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .Load(Load), .Up(Up), .Down(Down), .EN(EN),
    .STEP(STEP), .LIM_LO(LIM_LO), .LIM_HI(LIM_HI), .MODE(MODE),
    .Counter(Counter), .High(High), .Low(Low), .DIR(DIR), .TC(TC), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One count step, then check counter, DIR and TC.
  task automatic step_chk(input string tag, input logic [7:0] c, input logic d, input logic t);
    tick();
    check_val({tag, "_cnt"}, {24'd0, Counter}, {24'd0, c});
    check_val({tag, "_dir"}, {31'd0, DIR}, {31'd0, d});
    check_val({tag, "_tc"}, {31'd0, TC}, {31'd0, t});
  endtask

  task automatic load_val(input logic [7:0] v);
    Load = 1'b1; IN = v;
    tick();
    Load = 1'b0;
  endtask

  logic [7:0] bounce_exp [7] = '{8'd2, 8'd4, 8'd5, 8'd3, 8'd1, 8'd0, 8'd2};
  logic       bounce_dir [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       bounce_tc  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #2;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_val("rst_cnt", {24'd0, Counter}, 32'd0);
    check_val("rst_dir", {31'd0, DIR}, 32'd1);
    check_val("rst_tc", {31'd0, TC}, 32'd0);

    // Saturate mode: snap-in, ramp to 20, hold
    LIM_LO = 8'd10; LIM_HI = 8'd20; Up = 1'b1; EN = 1'b1; STEP = 8'd1; MODE = 2'd0;
    #1;
    check_val("pre_low", {31'd0, Low}, 32'd0);
    step_chk("snap", 8'd10, 1'b1, 1'b0);
    check_val("snap_low", {31'd0, Low}, 32'd1);
    for (int i = 11; i <= 20; i++) step_chk("sat_ramp", 8'(i), 1'b1, 1'b0);
    step_chk("sat_hold1", 8'd20, 1'b1, 1'b0);
    step_chk("sat_hold2", 8'd20, 1'b1, 1'b0);
    check_val("sat_high", {31'd0, High}, 32'd1);

    // STEP = 0 holds
    STEP = 8'd0; Up = 1'b0; Down = 1'b1;
    step_chk("step0", 8'd20, 1'b1, 1'b0);

    // Wrap mode
    Down = 1'b0;
    load_val(8'd18);
    check_val("ld18", {24'd0, Counter}, 32'd18);
    MODE = 2'd1; STEP = 8'd3; Up = 1'b1;
    step_chk("wrap_up", 8'd10, 1'b1, 1'b1);
    Up = 1'b0; Down = 1'b1;
    step_chk("wrap_dn", 8'd20, 1'b1, 1'b1);
    step_chk("wrap_dn2", 8'd17, 1'b1, 1'b0);

    // Bounce mode over 0..5, step 2
    Down = 1'b0; LIM_LO = 8'd0; LIM_HI = 8'd5; STEP = 8'd2; MODE = 2'd0;
    load_val(8'd0);
    MODE = 2'd2; Up = 1'b1;
    for (int i = 0; i < 7; i++) step_chk("bounce", bounce_exp[i], bounce_dir[i], bounce_tc[i]);

    // Load clamping and priority
    Up = 1'b0; MODE = 2'd0; LIM_LO = 8'd10; LIM_HI = 8'd20;
    load_val(8'd250);
    check_val("ld250", {24'd0, Counter}, 32'd20);
    load_val(8'd3);
    check_val("ld3", {24'd0, Counter}, 32'd10);
    Up = 1'b1; STEP = 8'd1;
    load_val(8'd15);
    check_val("ld_wins", {24'd0, Counter}, 32'd15);

    // Limit error freezes the counter
    LIM_LO = 8'd30; #1;
    check_val("err_on", {31'd0, ERR}, 32'd1);
    load_val(8'd12);
    check_val("err_ld", {24'd0, Counter}, 32'd15);
    step_chk("err_up", 8'd15, 1'b1, 1'b0);
    LIM_LO = 8'd10; #1;
    check_val("err_off", {31'd0, ERR}, 32'd0);
    step_chk("err_resume", 8'd16, 1'b1, 1'b0);

    // Down wins over Up
    load_val(8'd15);
    Down = 1'b1;
    step_chk("both", 8'd14, 1'b1, 1'b0);

    // Equal limits, wrap: every op pulses TC
    Down = 1'b0; LIM_LO = 8'd7; LIM_HI = 8'd7; MODE = 2'd1;
    step_chk("eq_snap", 8'd7, 1'b1, 1'b0);
    step_chk("eq_op1", 8'd7, 1'b1, 1'b1);
    step_chk("eq_op2", 8'd7, 1'b1, 1'b1);

    // Equal limits, bounce: DIR toggles each op
    MODE = 2'd2;
    step_chk("eqb_op1", 8'd7, 1'b0, 1'b1);
    step_chk("eqb_op2", 8'd7, 1'b1, 1'b1);

    // Reset mid-count after DIR has flipped
    LIM_LO = 8'd10; LIM_HI = 8'd20;
    load_val(8'd19);
    step_chk("pre_rst", 8'd20, 1'b0, 1'b1);
    RST = 1'b1;
    step_chk("mid_rst", 8'd0, 1'b1, 1'b0);
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
